// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer, so in_ready is registered-only.
// Accepting a beat that carries a halt marker latches halted, which blocks new beats until flush or rst.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic             halted
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_halt_q, main_halt_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_halt_q, skid_halt_d;
    logic             halted_q, halted_d;

    logic main_valid, skid_valid, accept, fire;

    // Validity and handshake terms come straight from the state register.
    assign main_valid = (state_q == S_ONE) || (state_q == S_FULL);
    assign skid_valid = (state_q == S_FULL);
    assign in_ready   = !skid_valid && !halted_q;
    assign out_valid  = main_valid;
    assign out_data   = main_data_q;
    assign out_halt   = main_halt_q;
    assign halted     = halted_q;
    assign occupancy  = 2'(main_valid) + 2'(skid_valid);

    assign accept = in_valid && in_ready && !flush;
    assign fire   = out_valid && out_ready && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_data_q <= RESET_VAL;
            main_halt_q <= 1'b0;
            skid_data_q <= RESET_VAL;
            skid_halt_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_halt_q <= main_halt_d;
            skid_data_q <= skid_data_d;
            skid_halt_q <= skid_halt_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and payload movement; emptied entries return to RESET_VAL.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_halt_d = main_halt_q;
        skid_data_d = skid_data_q;
        skid_halt_d = skid_halt_q;
        halted_d    = halted_q;

        if (flush) begin
            state_d     = S_EMPTY;
            main_data_d = RESET_VAL;
            main_halt_d = 1'b0;
            skid_data_d = RESET_VAL;
            skid_halt_d = 1'b0;
            halted_d    = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d     = S_ONE;
                        main_data_d = in_data;
                        main_halt_d = in_halt;
                    end
                end
                S_ONE: begin
                    if (accept && fire) begin
                        main_data_d = in_data;
                        main_halt_d = in_halt;
                    end else if (accept) begin
                        state_d     = S_FULL;
                        skid_data_d = in_data;
                        skid_halt_d = in_halt;
                    end else if (fire) begin
                        state_d     = S_EMPTY;
                        main_data_d = RESET_VAL;
                        main_halt_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (fire) begin
                        state_d     = S_ONE;
                        main_data_d = skid_data_q;
                        main_halt_d = skid_halt_q;
                        skid_data_d = RESET_VAL;
                        skid_halt_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = S_EMPTY;
                    main_data_d = RESET_VAL;
                    main_halt_d = 1'b0;
                    skid_data_d = RESET_VAL;
                    skid_halt_d = 1'b0;
                end
            endcase

            if (accept && in_halt) begin
                halted_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid: streaming, backpressure, halt, flush, reset,
// plus in-order lossless scoreboarding on 1-bit and 64-bit instances.
module tb_pipe_stage_skid;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_halt, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_halt, halted;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic       v1, f1, rd1, ir1, ov1, oh1, h1;
    logic [0:0] dat1, od1;
    logic [1:0] oc1;
    logic        v64, f64, rd64, ir64, ov64, oh64, h64;
    logic [63:0] dat64, od64;
    logic [1:0]  oc64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_halt(in_halt), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_halt(out_halt), .out_ready(out_ready), .occupancy(occupancy), .halted(halted)
    );

    pipe_stage_skid #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(v1), .in_data(dat1),
        .in_halt(1'b0), .in_ready(ir1), .out_valid(ov1), .out_data(od1),
        .out_halt(oh1), .out_ready(rd1), .occupancy(oc1), .halted(h1)
    );

    pipe_stage_skid #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst(rst), .flush(f64), .in_valid(v64), .in_data(dat64),
        .in_halt(1'b0), .in_ready(ir64), .out_valid(ov64), .out_data(od64),
        .out_halt(oh64), .out_ready(rd64), .occupancy(oc64), .halted(h64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data, RV); end
        checks++; if (out_halt !== 1'b0) begin errors++; $display("FAIL reset_out_halt got %0b want 0", out_halt); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_halt   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'(i);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i)); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occupancy[%0d] got %0d want 1", i, occupancy); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RV) begin errors++; $display("FAIL stream_drain got occ=%0d v=%0b d=%h want occ=0 v=0 d=%h", occupancy, out_valid, out_data, RV); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        checks++; if (occupancy !== 2'd1 || out_data !== 32'hA) begin errors++; $display("FAIL bp_one got occ=%0d d=%h want occ=1 d=a", occupancy, out_data); end
        in_data = 32'hB;
        step();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA || occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold got v=%0b d=%h occ=%0d want v=1 d=a occ=2", out_valid, out_data, occupancy); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 32'hB || occupancy !== 2'd1) begin errors++; $display("FAIL bp_second got d=%h occ=%0d want d=b occ=1", out_data, occupancy); end
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_halt();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5; in_halt = 1'b0;
        step();
        checks++; if (out_data !== 32'h5 || halted !== 1'b0) begin errors++; $display("FAIL halt_first got d=%h h=%0b want d=5 h=0", out_data, halted); end
        in_data = 32'h6; in_halt = 1'b1;
        step();
        checks++; if (out_data !== 32'h6 || out_halt !== 1'b1 || halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_marker got d=%h oh=%0b h=%0b rdy=%0b want d=6 oh=1 h=1 rdy=0", out_data, out_halt, halted, in_ready); end
        in_data = 32'h7; in_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_blocked[%0d] got v=%0b occ=%0d h=%0b rdy=%0b want v=0 occ=0 h=1 rdy=0", i, out_valid, occupancy, halted, in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear_halt got h=%0b rdy=%0b want h=0 rdy=1", halted, in_ready); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1; in_halt = 1'b0;
        step();
        in_data = 32'h2; in_halt = 1'b1;
        step();
        checks++; if (occupancy !== 2'd2 || halted !== 1'b1) begin errors++; $display("FAIL flush_setup got occ=%0d h=%0b want occ=2 h=1", occupancy, halted); end
        flush = 1'b1; in_data = 32'h9; in_halt = 1'b0; out_ready = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RV || out_halt !== 1'b0) begin errors++; $display("FAIL flush_outputs got occ=%0d v=%0b d=%h oh=%0b want occ=0 v=0 d=%h oh=0", occupancy, out_valid, out_data, out_halt, RV); end
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got h=%0b rdy=%0b want h=0 rdy=1", halted, in_ready); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data === 32'h9) begin errors++; $display("FAIL flush_discard got v=%0b d=%h want v=0 and not 9", out_valid, out_data); end
    endtask

    task automatic test_reset_priority();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_halt   = 1'b0;
        in_data   = 32'h3;
        step();
        in_data = 32'h4;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstp_setup got occ=%0d want 2", occupancy); end
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h55;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
    endtask

    task automatic test_random();
        logic [63:0] q64[$];
        logic [0:0]  q1[$];
        bit          ex_rdy1, ex_rdy64;
        for (int c = 0; c < 10000; c++) begin
            ex_rdy1  = q1.size() < 2;
            ex_rdy64 = q64.size() < 2;
            checks++; if (oc1 !== 2'(q1.size()) || ir1 !== ex_rdy1 || ov1 !== (q1.size() > 0)) begin errors++; $display("FAIL rand_w1_state[%0d] got occ=%0d rdy=%0b v=%0b want occ=%0d", c, oc1, ir1, ov1, q1.size()); end
            checks++; if (oc64 !== 2'(q64.size()) || ir64 !== ex_rdy64 || ov64 !== (q64.size() > 0)) begin errors++; $display("FAIL rand_w64_state[%0d] got occ=%0d rdy=%0b v=%0b want occ=%0d", c, oc64, ir64, ov64, q64.size()); end
            v1    = 1'($urandom_range(0, 1));
            rd1   = 1'($urandom_range(0, 1));
            dat1  = 1'($urandom);
            v64   = 1'($urandom_range(0, 1));
            rd64  = 1'($urandom_range(0, 1));
            dat64 = {$urandom, $urandom};
            if (q1.size() > 0 && rd1) begin
                checks++; if (od1 !== q1[0]) begin errors++; $display("FAIL rand_w1_data[%0d] got %h want %h", c, od1, q1[0]); end
                void'(q1.pop_front());
            end
            if (v1 && ex_rdy1) q1.push_back(dat1);
            if (q64.size() > 0 && rd64) begin
                checks++; if (od64 !== q64[0]) begin errors++; $display("FAIL rand_w64_data[%0d] got %h want %h", c, od64, q64[0]); end
                void'(q64.pop_front());
            end
            if (v64 && ex_rdy64) q64.push_back(dat64);
            step();
        end
        checks++; if (h1 !== 1'b0 || oh1 !== 1'b0 || h64 !== 1'b0 || oh64 !== 1'b0) begin errors++; $display("FAIL rand_halt got %0b%0b%0b%0b want 0000", h1, oh1, h64, oh64); end
        v1 = 1'b0; v64 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_halt = 1'b0; out_ready = 1'b0; in_data = '0;
        v1 = 1'b0; f1 = 1'b0; rd1 = 1'b0; dat1 = '0;
        v64 = 1'b0; f64 = 1'b0; rd64 = 1'b0; dat64 = '0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        step();
        test_reset();
        test_streaming();
        test_backpressure();
        test_halt();
        test_flush();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
